// File: rtl/sisc_fetch_queue.sv
// SISC instruction fetch stage: owns the fetch PC and buffers returned words in a prefetch queue for decode.
// Optional HALT-opcode stop is enabled by defining SISC_FETCH_HALT_EN.
module sisc_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [15:0]              im_addr,
  input  logic [31:0]              im_data,
  input  logic                     br_taken,
  input  logic [15:0]              br_addr,
  output logic                     ir_valid,
  output logic [31:0]              ir,
  output logic [15:0]              ir_pc,
  input  logic                     ir_ready,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [31:0]   r_memInstr [DEPTH];
  logic [15:0]   r_memPc    [DEPTH];
  logic [PW-1:0] r_headPtr;
  logic [PW-1:0] r_tailPtr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_pc;

  logic w_pop;
  logic w_push;
  logic w_full;
  logic w_haltWord;
  logic w_halted;

  assign w_full   = (r_count == CNT_FULL);
  assign w_pop    = (r_count != '0) && ir_ready;
  assign w_push   = !w_halted && (!w_full || w_pop);

`ifdef SISC_FETCH_HALT_EN
  logic r_halted;

  assign w_haltWord = (im_data[31:28] == 4'hF);
  assign w_halted   = r_halted;

  // Halt latches on the edge that pushes the HALT word; only a branch or reset restarts fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_halted <= 1'b0;
    end else if (br_taken) begin
      r_halted <= 1'b0;
    end else if (w_push && w_haltWord) begin
      r_halted <= 1'b1;
    end
  end
`else
  assign w_haltWord = 1'b0;
  assign w_halted   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_headPtr <= '0;
      r_tailPtr <= '0;
      r_count   <= '0;
    end else if (br_taken) begin
      r_pc      <= br_addr;
      r_headPtr <= '0;
      r_tailPtr <= '0;
      r_count   <= '0;
    end else begin
      if (w_push) begin
        r_tailPtr <= r_tailPtr + PTR_ONE;
        if (!w_haltWord) begin
          r_pc <= r_pc + 16'd1;
        end
      end
      if (w_pop) begin
        r_headPtr <= r_headPtr + PTR_ONE;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Entry storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && !br_taken && w_push) begin
      r_memInstr[r_tailPtr] <= im_data;
      r_memPc[r_tailPtr]    <= r_pc;
    end
  end

  assign im_addr  = r_pc;
  assign ir_valid = (r_count != '0);
  assign ir       = r_memInstr[r_headPtr];
  assign ir_pc    = r_memPc[r_headPtr];
  assign q_count  = r_count;
  assign halted   = w_halted;

endmodule

// File: tb/tb_sisc_fetch_queue.sv
// Directed bench for sisc_fetch_queue: DEPTH=4, RESET_PC=0010, memory word = A000_0000+address (F000_0000 at address 5).
module tb_sisc_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] im_addr;
  logic [31:0] im_data;
  logic        br_taken;
  logic [15:0] br_addr;
  logic        ir_valid;
  logic [31:0] ir;
  logic [15:0] ir_pc;
  logic        ir_ready;
  logic [2:0]  q_count;
  logic        halted;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign im_data = (im_addr == 16'h0005) ? 32'hF000_0000 : (32'hA000_0000 + {16'h0000, im_addr});

  sisc_fetch_queue #(.DEPTH(4), .RESET_PC(16'h0010)) dut (
    .clk(clk), .rst(rst), .im_addr(im_addr), .im_data(im_data),
    .br_taken(br_taken), .br_addr(br_addr), .ir_valid(ir_valid), .ir(ir),
    .ir_pc(ir_pc), .ir_ready(ir_ready), .q_count(q_count), .halted(halted)
  );

  task automatic applyStimulus(input logic rstV, input logic readyV, input logic brV, input logic [15:0] addrV);
    rst      = rstV;
    ir_ready = readyV;
    br_taken = brV;
    br_addr  = addrV;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1; ir_ready = 1'b1; br_taken = 1'b0; br_addr = 16'h0000;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("rst_qcount", 32'(q_count), 32'd0);
    checkOutput("rst_valid", 32'(ir_valid), 32'd0);
    checkOutput("rst_imaddr", 32'(im_addr), 32'h0010);
    checkOutput("rst_halted", 32'(halted), 32'd0);

    // Streaming: one instruction per cycle from RESET_PC.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("stream_valid0", 32'(ir_valid), 32'd1);
    checkOutput("stream_pc0", 32'(ir_pc), 32'h0010);
    checkOutput("stream_ir0", ir, 32'hA000_0010);
    checkOutput("stream_imaddr0", 32'(im_addr), 32'h0011);
    checkOutput("stream_qcount0", 32'(q_count), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("stream_pc1", 32'(ir_pc), 32'h0011);
    checkOutput("stream_ir1", ir, 32'hA000_0011);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("stream_pc2", 32'(ir_pc), 32'h0012);
    checkOutput("stream_valid2", 32'(ir_valid), 32'd1);

    // Stall: decode not ready, queue fills and fetch freezes at 0014.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput($sformatf("stall_qcount%0d", i), 32'(q_count), (i < 4) ? 32'(i + 1) : 32'd4);
      checkOutput($sformatf("stall_imaddr%0d", i), 32'(im_addr), (i < 4) ? 32'(16'h0011 + i) : 32'h0014);
      checkOutput($sformatf("stall_head%0d", i), 32'(ir_pc), 32'h0010);
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain_pc%0d", i), 32'(ir_pc), 32'(16'h0010 + i));
      checkOutput($sformatf("drain_qcount%0d", i), 32'(q_count), 32'd4);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    end
    checkOutput("drain_pc_after", 32'(ir_pc), 32'h0014);
    checkOutput("drain_ir_after", ir, 32'hA000_0014);
    checkOutput("drain_qcount_after", 32'(q_count), 32'd4);
    checkOutput("drain_imaddr_after", 32'(im_addr), 32'h0018);

    // Branch while full and popping.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0200);
    checkOutput("br_qcount", 32'(q_count), 32'd0);
    checkOutput("br_valid", 32'(ir_valid), 32'd0);
    checkOutput("br_imaddr", 32'(im_addr), 32'h0200);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("br_target_valid", 32'(ir_valid), 32'd1);
    checkOutput("br_target_pc", 32'(ir_pc), 32'h0200);
    checkOutput("br_target_ir", ir, 32'hA000_0200);
    checkOutput("br_target_qcount", 32'(q_count), 32'd1);

    // PC wrap FFFE -> FFFF -> 0000.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFE);
    checkOutput("wrap_imaddr", 32'(im_addr), 32'hFFFE);
    checkOutput("wrap_valid", 32'(ir_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("wrap_pc0", 32'(ir_pc), 32'hFFFE);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("wrap_pc1", 32'(ir_pc), 32'hFFFF);
    checkOutput("wrap_ir1", ir, 32'hA000_FFFF);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("wrap_pc2", 32'(ir_pc), 32'h0000);
    checkOutput("wrap_ir2", ir, 32'hA000_0000);
    checkOutput("wrap_imaddr2", 32'(im_addr), 32'h0001);

    // Reset mid-stream with three entries held.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0300);
    checkOutput("mid_br_qcount", 32'(q_count), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("mid_qcount3", 32'(q_count), 32'd3);
    checkOutput("mid_head", 32'(ir_pc), 32'h0300);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("mid_rst_qcount", 32'(q_count), 32'd0);
    checkOutput("mid_rst_valid", 32'(ir_valid), 32'd0);
    checkOutput("mid_rst_imaddr", 32'(im_addr), 32'h0010);
    checkOutput("mid_rst_halted", 32'(halted), 32'd0);

    // HALT word at address 5.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0003);
    checkOutput("halt_br_imaddr", 32'(im_addr), 32'h0003);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("halt_pc3", 32'(ir_pc), 32'h0003);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("halt_pc4", 32'(ir_pc), 32'h0004);
    checkOutput("halt_imaddr5", 32'(im_addr), 32'h0005);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("halt_word_valid", 32'(ir_valid), 32'd1);
    checkOutput("halt_word_pc", 32'(ir_pc), 32'h0005);
    checkOutput("halt_word_ir", ir, 32'hF000_0000);
`ifdef SISC_FETCH_HALT_EN
    checkOutput("halt_set", 32'(halted), 32'd1);
    checkOutput("halt_imaddr_hold", 32'(im_addr), 32'h0005);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("halt_drained_valid", 32'(ir_valid), 32'd0);
    checkOutput("halt_drained_qcount", 32'(q_count), 32'd0);
    checkOutput("halt_drained_imaddr", 32'(im_addr), 32'h0005);
    checkOutput("halt_still", 32'(halted), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("halt_idle_valid", 32'(ir_valid), 32'd0);
    checkOutput("halt_idle_imaddr", 32'(im_addr), 32'h0005);
`else
    checkOutput("nohalt_flag", 32'(halted), 32'd0);
    checkOutput("nohalt_imaddr", 32'(im_addr), 32'h0006);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("nohalt_pc6", 32'(ir_pc), 32'h0006);
    checkOutput("nohalt_imaddr7", 32'(im_addr), 32'h0007);
    checkOutput("nohalt_flag2", 32'(halted), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("nohalt_pc7", 32'(ir_pc), 32'h0007);
`endif
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000);
    checkOutput("unhalt_flag", 32'(halted), 32'd0);
    checkOutput("unhalt_imaddr", 32'(im_addr), 32'h0000);
    checkOutput("unhalt_valid", 32'(ir_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("unhalt_pc", 32'(ir_pc), 32'h0000);
    checkOutput("unhalt_valid2", 32'(ir_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
